// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the cascaded BCD stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_next(input logic [3:0] d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command/target/status bundle between a user front end and stopwatch_ctrl.
interface stopwatch_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  cmd_start;
  logic                  cmd_stop;
  logic                  cmd_clear;
  logic [4*DIGITS-1:0]   target;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic [1:0]            state;

  modport master (
    output cmd_start, cmd_stop, cmd_clear, target,
    input  count, running, done, state
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, target,
    output count, running, done, state
  );
endinterface

// File: rtl/bcd_digit.sv
// One decade digit: counts 0..9 on inc, wraps to 0, flags when at 9.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       at_max
);

  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = bcd_next(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch: prescaled tick, rippled BCD digits, stop at target.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stopwatch_ctrl_if.slave        bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  state_e            state_d, state_q;
  logic [PreW-1:0]   pre_d, pre_q;
  logic              done_d, done_q;

  logic              tick;
  logic              hit;
  logic              clr_cnt;
  logic              start_eff;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] at_max;
  logic [W-1:0]      count_w;
  logic [W-1:0]      next_count;

  // Stop or clear in the terminal prescaler cycle suppresses the tick.
  assign tick = (state_q == StRun) && (pre_q == PreLast) && !bus.cmd_stop && !bus.cmd_clear;

  always_comb begin
    logic carry;
    carry = tick;
    for (int i = 0; i < DIGITS; i++) begin
      inc[i] = carry;
      carry  = carry & at_max[i];
    end
  end

  always_comb begin
    next_count = count_w;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc[i]) begin
        next_count[4*i +: 4] = bcd_next(count_w[4*i +: 4]);
      end
    end
  end

  assign hit       = tick && (next_count == bus.target);
  assign start_eff = bus.cmd_start && !bus.cmd_stop;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    clr_cnt = 1'b0;
    if (bus.cmd_clear) begin
      state_d = StIdle;
      pre_d   = '0;
      clr_cnt = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          pre_d = '0;
          if (start_eff) state_d = StRun;
        end
        StRun: begin
          if (bus.cmd_stop) begin
            state_d = StPause;
          end else if (hit) begin
            state_d = StDone;
            pre_d   = '0;
            done_d  = 1'b1;
          end else begin
            pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
          end
        end
        StPause: begin
          if (start_eff) state_d = StRun;
        end
        StDone: begin
          pre_d = '0;
          if (start_eff) begin
            state_d = StRun;
            clr_cnt = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr_cnt),
      .inc    (inc[g]),
      .q      (count_w[4*g +: 4]),
      .at_max (at_max[g])
    );
  end

  assign bus.count   = count_w;
  assign bus.running = (state_q == StRun);
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIGITS=2, PRESCALE=2.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stopwatch_ctrl_if #(.DIGITS(2)) bus ();

  stopwatch_ctrl #(
    .DIGITS   (2),
    .PRESCALE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] cnt, input logic [1:0] st,
                           input logic run, input logic dn);
    check({tag, ".count"},   32'(bus.count),   32'(cnt));
    check({tag, ".state"},   32'(bus.state),   32'(st));
    check({tag, ".running"}, 32'(bus.running), 32'(run));
    check({tag, ".done"},    32'(bus.done),    32'(dn));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.target    = 8'h05;
    cyc(2);
    check_all("reset", 8'h00, 2'd0, 1'b0, 1'b0);

    // 1: count to target 05
    rst_n = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    check_all("t1_start", 8'h00, 2'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(2);
      check("t1_cnt", 32'(bus.count), k);
    end
    cyc(1);
    check_all("t1_pre_done", 8'h04, 2'd1, 1'b1, 1'b0);
    cyc(1);
    check_all("t1_done", 8'h05, 2'd3, 1'b0, 1'b1);
    cyc(1);
    check_all("t1_after", 8'h05, 2'd3, 1'b0, 1'b0);
    cyc(4);
    check_all("t1_hold", 8'h05, 2'd3, 1'b0, 1'b0);

    // Restart from DONE zeroes the count; then stop on the pre=1 cycle
    bus.target    = 8'h20;
    bus.cmd_start = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    check_all("done_restart", 8'h00, 2'd1, 1'b1, 1'b0);
    cyc(1);
    bus.cmd_stop = 1'b1;
    cyc(1);
    bus.cmd_stop = 1'b0;
    check_all("t2_pause", 8'h00, 2'd2, 1'b0, 1'b0);
    cyc(3);
    check("t2_pause_hold", 32'(bus.count), 32'h00);
    bus.cmd_start = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    check_all("t2_resume", 8'h00, 2'd1, 1'b1, 1'b0);
    cyc(1);
    check("t2_first_inc", 32'(bus.count), 32'h01);
    cyc(2);
    check("t2_second_inc", 32'(bus.count), 32'h02);

    // 3: digit carry 09 -> 10, then 99 -> 00 with a non-BCD target
    cyc(14);
    check("t3_09", 32'(bus.count), 32'h09);
    cyc(2);
    check("t3_10", 32'(bus.count), 32'h10);
    bus.target = 8'h0A;
    cyc(178);
    check("t3_99", 32'(bus.count), 32'h99);
    cyc(2);
    check_all("t3_wrap", 8'h00, 2'd1, 1'b1, 1'b0);
    cyc(200);
    check_all("t6_wrap2", 8'h00, 2'd1, 1'b1, 1'b0);

    // 4: all commands together at 07 -> clear wins
    cyc(14);
    check("t4_07", 32'(bus.count), 32'h07);
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    bus.cmd_clear = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_clear = 1'b0;
    check_all("t4_clear", 8'h00, 2'd0, 1'b0, 1'b0);
    cyc(3);
    check("t4_idle_hold", 32'(bus.count), 32'h00);

    // 5: reset mid-run at 42
    bus.cmd_start = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    check_all("t5_start", 8'h00, 2'd1, 1'b1, 1'b0);
    cyc(84);
    check("t5_42", 32'(bus.count), 32'h42);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check_all("t5_reset", 8'h00, 2'd0, 1'b0, 1'b0);
    bus.cmd_start = 1'b1;
    cyc(1);
    bus.cmd_start = 1'b0;
    check_all("t5_restart", 8'h00, 2'd1, 1'b1, 1'b0);
    cyc(2);
    check("t5_first", 32'(bus.count), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
